ahb_sram_slave: RTL and testbench

//  AHB-Lite single-port SRAM slave. Sits downstream of the Hbus master/decoder:
//  it consumes HADDR/HTRANS/HWDATA and produces the HRDATA/HREADYOUT/HRESP fed back through the read mux.

---
 rtl/ahb_sram_slave.sv | 138 +++++++++++++
 tb/tb_ahb_sram_slave.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module  : ahb_sram_slave
// Brief   : AHB-Lite single-port SRAM slave. It implements the address/data
//           phase pipeline, programmable wait states, little-endian byte
//           lanes and the two-cycle ERROR response.
// Revision: 1.0 - initial release
// ============================================================================
module ahb_sram_slave #(
  parameter int DATAWIDTH   = 32,
  parameter int ADDRWIDTH   = 32,
  parameter int Trans_Width = 2,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic                   HSEL,
  input  logic [ADDRWIDTH-1:0]   HADDR,
  input  logic [Trans_Width-1:0] HTRANS,
  input  logic                   HWRITE,
  input  logic [2:0]             HSIZE,
  input  logic [DATAWIDTH-1:0]   HWDATA,
  input  logic                   HREADY,
  output logic [DATAWIDTH-1:0]   HRDATA,
  output logic                   HREADYOUT,
  output logic                   HRESP
);

  localparam int                   IDX_W      = $clog2(MEM_DEPTH);
  localparam logic [ADDRWIDTH-1:0] ADDR_LIMIT = ADDRWIDTH'(MEM_DEPTH * 4);
  localparam logic [3:0]           WAIT_INIT  = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  state_t               state;
  logic [3:0]           cnt;
  logic [IDX_W-1:0]     idx;
  logic [1:0]           lane;
  logic [2:0]           size;
  logic                 write;
  logic                 ready;
  logic                 resp;
  logic [3:0]           be;
  logic                 accept;
  logic                 addr_err;
  logic                 data_done;
  logic                 unused_trans;

  logic [DATAWIDTH-1:0] mem [MEM_DEPTH];

  // HTRANS[0] only separates BUSY from IDLE and NONSEQ from SEQ; neither matters here.
  assign unused_trans = HTRANS[0];

  assign accept    = HSEL & HREADY & HTRANS[1];
  assign data_done = (state == ST_DATA) && (cnt == 4'd0);

  // Address-phase legality: out of range, oversize, or misaligned access
  always_comb begin
    addr_err = 1'b0;
    if (HADDR >= ADDR_LIMIT)                        addr_err = 1'b1;
    if (HSIZE > 3'b010)                             addr_err = 1'b1;
    if ((HSIZE == 3'b001) && HADDR[0])              addr_err = 1'b1;
    if ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00)) addr_err = 1'b1;
  end

  // Byte-lane enables for the latched transfer (little-endian)
  always_comb begin
    be = 4'b1111;
    case (size)
      3'b000:  be = 4'b0001 << lane;
      3'b001:  be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Transfer FSM with registered HREADYOUT/HRESP
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
      idx   <= '0;
      lane  <= 2'b00;
      size  <= 3'b000;
      write <= 1'b0;
      ready <= 1'b1;
      resp  <= 1'b0;
    end else if (state == ST_ERR1) begin
      state <= ST_ERR2;
      ready <= 1'b1;
      resp  <= 1'b1;
    end else if ((state == ST_DATA) && (cnt != 4'd0)) begin
      cnt   <= cnt - 4'd1;
      ready <= (cnt == 4'd1);
    end else if (accept) begin
      // IDLE, or a completing DATA/ERR2 cycle: take the next transfer without a bubble
      idx   <= HADDR[IDX_W+1:2];
      lane  <= HADDR[1:0];
      size  <= HSIZE;
      write <= HWRITE;
      if (addr_err) begin
        state <= ST_ERR1;
        ready <= 1'b0;
        resp  <= 1'b1;
      end else begin
        state <= ST_DATA;
        cnt   <= WAIT_INIT;
        ready <= (WAIT_INIT == 4'd0);
        resp  <= 1'b0;
      end
    end else begin
      state <= ST_IDLE;
      ready <= 1'b1;
      resp  <= 1'b0;
    end
  end

  // Write commit on the completing edge; the array itself is never reset
  always_ff @(posedge HCLK) begin
    if (HRESETn && data_done && write) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  assign HREADYOUT = ready;
  assign HRESP     = resp;
  // Full word on the completing read cycle only, zero elsewhere
  assign HRDATA    = (data_done && !write) ? mem[idx] : '0;

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module  : tb_ahb_sram_slave
// Brief   : Scoreboard bench for ahb_sram_slave. A zero-wait and a two-wait
//           instance share the bus; the driver pushes expected responses and
//           a monitor pops them at each data-phase completion.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ahb_sram_slave;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        hsel;
  logic        sel;
  logic        hready_ext;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;

  logic [31:0] rdata0, rdata1;
  logic        ro0, ro1, rsp0, rsp1;
  logic        sel0_hsel, sel1_hsel;
  logic        hready0, hready1;
  logic [31:0] m_rdata;
  logic        m_ready, m_resp;

  typedef struct {
    bit          resp;
    logic [31:0] data;
    bit          chk;
    int          waits;
    string       tag;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] pend;

  always #5 HCLK = ~HCLK;

  assign sel0_hsel = hsel & ~sel;
  assign sel1_hsel = hsel & sel;
  assign hready0   = hready_ext & ro0;
  assign hready1   = hready_ext & ro1;
  assign m_rdata   = sel ? rdata1 : rdata0;
  assign m_ready   = sel ? ro1 : ro0;
  assign m_resp    = sel ? rsp1 : rsp0;

  ahb_sram_slave #(.WAIT_STATES(0)) u_w0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel0_hsel), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADY(hready0), .HRDATA(rdata0), .HREADYOUT(ro0), .HRESP(rsp0)
  );

  ahb_sram_slave #(.WAIT_STATES(2)) u_w2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel1_hsel), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADY(hready1), .HRDATA(rdata1), .HREADYOUT(ro1), .HRESP(rsp1)
  );

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // One address phase; returns just after the edge that accepted it
  task automatic phase(input bit s, input logic [1:0] t, input logic [31:0] a,
                       input bit w, input logic [2:0] sz, input logic [31:0] wd,
                       input bit push, input bit er, input logic [31:0] rd, input bit chk);
    exp_t e;
    int   n;
    hsel   = s;
    HTRANS = t;
    HADDR  = a;
    HWRITE = w;
    HSIZE  = sz;
    HWDATA = pend;
    if (push) begin
      e.resp  = er;
      e.data  = rd;
      e.chk   = chk;
      e.waits = er ? 1 : (sel ? 2 : 0);
      e.tag   = $sformatf("%s%0d@%08h", w ? "wr" : "rd", sel ? 2 : 0, a);
      q.push_back(e);
    end
    n = 0;
    @(negedge HCLK);
    while (!(hready_ext && m_ready) && n < 50) begin
      n++;
      @(negedge HCLK);
    end
    if (n >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got no HREADY for %08h expected HREADY within 50 cycles", a);
    end
    @(posedge HCLK);
    #1;
    pend = wd;
  endtask

  task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    phase(1'b1, 2'b10, a, 1'b1, sz, wd, 1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp);
    phase(1'b1, 2'b10, a, 1'b0, 3'b010, 32'h0, 1'b1, 1'b0, exp, 1'b1);
  endtask

  task automatic er(input logic [31:0] a, input bit w, input logic [2:0] sz);
    phase(1'b1, 2'b10, a, w, sz, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0, 1'b1);
  endtask

  task automatic idle();
    phase(1'b0, 2'b00, 32'h0, 1'b0, 3'b010, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // Monitor: tracks the data phase of the selected slave and scores it
  initial begin
    bit   in_dp;
    int   waits;
    exp_t e;
    in_dp = 1'b0;
    waits = 0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        if (in_dp && q.size() > 0) void'(q.pop_front());
        in_dp = 1'b0;
        cmp("rst_hreadyout", m_ready, 1);
        cmp("rst_hresp", m_resp, 0);
        cmp("rst_hrdata", m_rdata, 0);
      end else begin
        if (in_dp) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_empty: got a data phase expected no transfer");
            in_dp = 1'b0;
          end else if (m_ready) begin
            e = q.pop_front();
            cmp({e.tag, "_waits"}, waits, e.waits);
            cmp({e.tag, "_hresp"}, m_resp, e.resp);
            if (e.chk) cmp({e.tag, "_hrdata"}, m_rdata, e.data);
            in_dp = 1'b0;
          end else begin
            waits++;
            cmp({q[0].tag, "_wait_hresp"}, m_resp, q[0].resp);
            cmp({q[0].tag, "_wait_hrdata"}, m_rdata, 0);
          end
        end else begin
          cmp("idle_hreadyout", m_ready, 1);
          cmp("idle_hresp", m_resp, 0);
          cmp("idle_hrdata", m_rdata, 0);
        end
        if (hready_ext && m_ready && hsel && HTRANS[1]) begin
          in_dp = 1'b1;
          waits = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESETn    = 1'b0;
    hsel       = 1'b0;
    sel        = 1'b0;
    hready_ext = 1'b1;
    HADDR      = 32'h0;
    HTRANS     = 2'b00;
    HWRITE     = 1'b0;
    HSIZE      = 3'b010;
    HWDATA     = 32'h0;
    pend       = 32'h0;
    repeat (3) @(posedge HCLK);
    #3 HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    // Zero-wait write then read of the same word
    wr(32'h10, 3'b010, 32'hDEAD_BEEF);
    rd(32'h10, 32'hDEAD_BEEF);
    idle();

    // Byte and halfword lanes merge into the existing word
    wr(32'h11, 3'b000, 32'h0000_AA00);
    wr(32'h12, 3'b001, 32'h1234_0000);
    rd(32'h10, 32'h1234_AAEF);
    idle();

    // Error responses leave memory untouched; last word is still in range
    wr(32'h00, 3'b010, 32'h5566_7788);
    wr(32'h3FC, 3'b010, 32'hA5A5_A5A5);
    er(32'h400, 1'b0, 3'b010);
    er(32'h02, 1'b1, 3'b010);
    er(32'h13, 1'b1, 3'b001);
    er(32'h10, 1'b0, 3'b011);
    rd(32'h00, 32'h5566_7788);
    rd(32'h3FC, 32'hA5A5_A5A5);
    rd(32'h10, 32'h1234_AAEF);
    idle();

    // BUSY and IDLE with HSEL high are zero-wait OKAY and write nothing
    phase(1'b1, 2'b01, 32'h10, 1'b1, 3'b010, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    phase(1'b1, 2'b00, 32'h10, 1'b1, 3'b010, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    rd(32'h10, 32'h1234_AAEF);
    idle();

    // Another slave stalling: a NONSEQ with HREADY low must not be taken
    hsel = 1'b1; HTRANS = 2'b10; HADDR = 32'h10; HWRITE = 1'b0; HSIZE = 3'b010;
    hready_ext = 1'b0;
    @(posedge HCLK);
    #1;
    hready_ext = 1'b1; hsel = 1'b0; HTRANS = 2'b00;
    @(posedge HCLK);
    #1;

    // Two-wait instance: waits, back-to-back reads, error
    sel = 1'b1;
    wr(32'h10, 3'b010, 32'hDEAD_BEEF);
    rd(32'h10, 32'hDEAD_BEEF);
    rd(32'h10, 32'hDEAD_BEEF);
    er(32'h400, 1'b0, 3'b010);
    wr(32'h20, 3'b010, 32'hCAFE_F00D);
    idle();

    // Reset during the second wait cycle of a write abandons it
    wr(32'h20, 3'b010, 32'h0BAD_BEEF);
    hsel = 1'b0; HTRANS = 2'b00; HWDATA = pend;
    @(posedge HCLK);
    #1;
    cmp("pre_rst_hreadyout", m_ready, 0);
    HRESETn = 1'b0;
    #1;
    cmp("async_rst_hreadyout", m_ready, 1);
    cmp("async_rst_hresp", m_resp, 0);
    cmp("async_rst_hrdata", m_rdata, 0);
    repeat (2) @(posedge HCLK);
    #3 HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    pend = 32'h0;
    rd(32'h20, 32'hCAFE_F00D);
    idle();

    repeat (3) @(posedge HCLK);
    cmp("sb_drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
